// File: rtl/pipelined_datapath.sv
// Register file + ALU with one registered EX->WB stage and WB->EX forwarding.
// Optional DP_FLAGS_EN macro adds registered carry/overflow/negative flags.
module pipelined_datapath #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned RW      = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [RW-1:0]   read_reg_num1,
    input  logic [RW-1:0]   read_reg_num2,
    input  logic [RW-1:0]   write_reg,
    input  logic            regwrite,
    input  logic            use_imm,
    input  logic [XLEN-1:0] imm,
    input  logic [3:0]      alu_control,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            zero_flag
`ifdef DP_FLAGS_EN
    ,
    output logic            carry_flag,
    output logic            overflow_flag,
    output logic            negative_flag
`endif
);
    localparam int unsigned SW = $clog2(XLEN);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            r_valid;
    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic            r_wb_we;
    logic [RW-1:0]   r_wb_addr;

    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_rb;
    logic [XLEN-1:0] w_b;
    logic [XLEN-1:0] w_alu;
    logic [SW-1:0]   w_shamt;
    logic            w_fwd_a;
    logic            w_fwd_b;
    logic            w_commit;

    // A pending write to the hardwired zero register is neither committed nor forwarded.
    assign w_commit = r_wb_we && !(ZERO_REG && (r_wb_addr == '0));

    always_comb begin
        w_fwd_a = w_commit && (r_wb_addr == read_reg_num1);
        w_fwd_b = w_commit && (r_wb_addr == read_reg_num2);
        if (ZERO_REG && (read_reg_num1 == '0)) begin
            w_a = '0;
        end else if (w_fwd_a) begin
            w_a = r_result;
        end else begin
            w_a = r_regs[read_reg_num1];
        end
        if (ZERO_REG && (read_reg_num2 == '0)) begin
            w_rb = '0;
        end else if (w_fwd_b) begin
            w_rb = r_result;
        end else begin
            w_rb = r_regs[read_reg_num2];
        end
        w_b     = use_imm ? imm : w_rb;
        w_shamt = w_b[SW-1:0];
    end

    always_comb begin
        w_alu = '0;
        case (alu_control)
            4'b0000: w_alu = w_a & w_b;
            4'b0001: w_alu = w_a | w_b;
            4'b0010: w_alu = w_a + w_b;
            4'b0011: w_alu = w_a ^ w_b;
            4'b0110: w_alu = w_a - w_b;
            4'b0111: w_alu = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            4'b0101: w_alu = {{(XLEN-1){1'b0}}, (w_a < w_b)};
            4'b1100: w_alu = ~(w_a | w_b);
            4'b1000: w_alu = w_a << w_shamt;
            4'b1001: w_alu = w_a >> w_shamt;
            4'b1010: w_alu = XLEN'($signed(w_a) >>> w_shamt);
            default: w_alu = '0;
        endcase
    end

`ifdef DP_FLAGS_EN
    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_diff;
    logic          w_carry;
    logic          w_ovf;
    logic          r_carry;
    logic          r_ovf;
    logic          r_neg;

    // Subtraction as a + ~b + 1 so the carry out is the inverted borrow.
    always_comb begin
        w_sum   = {1'b0, w_a} + {1'b0, w_b};
        w_diff  = {1'b0, w_a} + {1'b0, ~w_b} + (XLEN+1)'(1);
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        if (alu_control == 4'b0010) begin
            w_carry = w_sum[XLEN];
            w_ovf   = (w_a[XLEN-1] == w_b[XLEN-1]) && (w_sum[XLEN-1] != w_a[XLEN-1]);
        end else if (alu_control == 4'b0110) begin
            w_carry = w_diff[XLEN];
            w_ovf   = (w_a[XLEN-1] != w_b[XLEN-1]) && (w_diff[XLEN-1] != w_a[XLEN-1]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_neg   <= 1'b0;
        end else if (in_valid) begin
            r_carry <= w_carry;
            r_ovf   <= w_ovf;
            r_neg   <= w_alu[XLEN-1];
        end
    end

    assign carry_flag    = r_carry;
    assign overflow_flag = r_ovf;
    assign negative_flag = r_neg;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_wb_we   <= 1'b0;
            r_wb_addr <= '0;
        end else begin
            if (w_commit) begin
                r_regs[r_wb_addr] <= r_result;
            end
            r_valid   <= in_valid;
            r_wb_we   <= regwrite && in_valid;
            r_wb_addr <= write_reg;
            // Bubbles leave the presented result and flags untouched.
            if (in_valid) begin
                r_result <= w_alu;
                r_zero   <= (w_alu == '0);
            end
        end
    end

    assign out_valid = r_valid;
    assign result    = r_result;
    assign zero_flag = r_zero;

endmodule

// File: tb/tb_pipelined_datapath.sv
// Table-driven bench for pipelined_datapath (XLEN=32, NREGS=32, ZERO_REG=1).
module tb_pipelined_datapath;
    localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD = 4'b0010, XOR_ = 4'b0011;
    localparam logic [3:0] SUB = 4'b0110, SLT = 4'b0111, SLTU = 4'b0101, NOR_ = 4'b1100;
    localparam logic [3:0] SLL = 4'b1000, SRL = 4'b1001, SRA = 4'b1010, BAD = 4'b0100;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [4:0]  read_reg_num1, read_reg_num2, write_reg;
    logic        regwrite, use_imm;
    logic [31:0] imm;
    logic [3:0]  alu_control;
    logic        out_valid;
    logic [31:0] result;
    logic        zero_flag;
`ifdef DP_FLAGS_EN
    logic        carry_flag, overflow_flag, negative_flag;
`endif

    int checks   = 0;
    int failures = 0;

    pipelined_datapath #(.XLEN(32), .NREGS(32), .ZERO_REG(1'b1)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .read_reg_num1 (read_reg_num1),
        .read_reg_num2 (read_reg_num2),
        .write_reg     (write_reg),
        .regwrite      (regwrite),
        .use_imm       (use_imm),
        .imm           (imm),
        .alu_control   (alu_control),
        .out_valid     (out_valid),
        .result        (result),
        .zero_flag     (zero_flag)
`ifdef DP_FLAGS_EN
        ,
        .carry_flag    (carry_flag),
        .overflow_flag (overflow_flag),
        .negative_flag (negative_flag)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic        we, ui;
        logic [31:0] imm;
        logic [3:0]  ctl;
        logic        ev;
        logic [31:0] er;
        logic        ez, ec, eo, en;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                logic we, logic ui, logic [31:0] im, logic [3:0] ctl,
                                logic ev, logic [31:0] er, logic ez,
                                logic ec, logic eo, logic en);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.we = we; t.ui = ui;
        t.imm = im; t.ctl = ctl; t.ev = ev; t.er = er; t.ez = ez;
        t.ec = ec; t.eo = eo; t.en = en;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_out(string tag, vec_t t);
        chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, t.ev});
        chk({tag, " result"}, result, t.er);
        chk({tag, " zero_flag"}, {31'd0, zero_flag}, {31'd0, t.ez});
`ifdef DP_FLAGS_EN
        chk({tag, " carry"}, {31'd0, carry_flag}, {31'd0, t.ec});
        chk({tag, " overflow"}, {31'd0, overflow_flag}, {31'd0, t.eo});
        chk({tag, " negative"}, {31'd0, negative_flag}, {31'd0, t.en});
`endif
    endtask

    task automatic step(vec_t t, string tag);
        in_valid = t.v; read_reg_num1 = t.rs1; read_reg_num2 = t.rs2; write_reg = t.rd;
        regwrite = t.we; use_imm = t.ui; imm = t.imm; alu_control = t.ctl;
        @(posedge clock);
        #1;
        chk_out(tag, t);
    endtask

    initial begin
        vec_t t;
        reset = 1'b1;
        t = mk(0, 0, 0, 0, 0, 0, 0, ADD, 0, 0, 0, 0, 0, 0);
        in_valid = 0; read_reg_num1 = 0; read_reg_num2 = 0; write_reg = 0;
        regwrite = 0; use_imm = 0; imm = 0; alu_control = ADD;
        repeat (2) @(posedge clock);
        #1;
        chk_out("reset", t);
        reset = 1'b0;

        //        v rs1 rs2 rd we ui imm           ctl   ev result        z  c  o  n
        vq.push_back(mk(1, 0, 0, 1, 1, 1, 32'd5, ADD, 1, 32'd5, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 2, 1, 1, 32'd7, ADD, 1, 32'd7, 0, 0, 0, 0));
        vq.push_back(mk(1, 1, 2, 3, 1, 0, 32'd0, SUB, 1, 32'hFFFF_FFFE, 0, 0, 0, 1));
        vq.push_back(mk(1, 0, 0, 4, 1, 1, 32'd10, ADD, 1, 32'd10, 0, 0, 0, 0));
        vq.push_back(mk(1, 4, 4, 5, 1, 0, 32'd0, ADD, 1, 32'd20, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 11, 1, 1, 32'd10, ADD, 1, 32'd10, 0, 0, 0, 0));
        // Bubble with regwrite high must not write r31.
        vq.push_back(mk(0, 0, 0, 31, 1, 1, 32'd99, ADD, 0, 32'd10, 0, 0, 0, 0));
        vq.push_back(mk(1, 11, 11, 12, 1, 0, 32'd0, ADD, 1, 32'd20, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 1, 1, 32'd9, ADD, 1, 32'd9, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 6, 1, 0, 32'd0, OR_, 1, 32'd0, 1, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 7, 1, 1, 32'h8000_0000, ADD, 1, 32'h8000_0000, 0, 0, 0, 1));
        vq.push_back(mk(1, 7, 0, 13, 1, 1, 32'd33, SRA, 1, 32'hC000_0000, 0, 0, 0, 1));
        vq.push_back(mk(1, 7, 0, 14, 1, 1, 32'd31, SRL, 1, 32'd1, 0, 0, 0, 0));
        vq.push_back(mk(1, 7, 0, 15, 1, 0, 32'd0, SLT, 1, 32'd1, 0, 0, 0, 0));
        vq.push_back(mk(1, 7, 0, 16, 1, 0, 32'd0, SLTU, 1, 32'd0, 1, 0, 0, 0));
        vq.push_back(mk(1, 1, 0, 17, 1, 1, 32'h0F, AND_, 1, 32'd5, 0, 0, 0, 0));
        vq.push_back(mk(1, 2, 0, 18, 1, 1, 32'hFF, XOR_, 1, 32'hF8, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 19, 1, 0, 32'd0, NOR_, 1, 32'hFFFF_FFFF, 0, 0, 0, 1));
        vq.push_back(mk(1, 1, 0, 20, 1, 1, 32'd4, SLL, 1, 32'h50, 0, 0, 0, 0));
        vq.push_back(mk(1, 1, 0, 21, 1, 1, 32'd1, BAD, 1, 32'd0, 1, 0, 0, 0));
        vq.push_back(mk(1, 7, 7, 22, 1, 0, 32'd0, ADD, 1, 32'd0, 1, 1, 1, 0));
        vq.push_back(mk(1, 1, 1, 23, 1, 0, 32'd0, SUB, 1, 32'd0, 1, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 9, 0, 1, 32'd4, ADD, 1, 32'd4, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 9, 0, 1, 32'd0, ADD, 0, 32'd4, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 9, 0, 1, 32'd0, ADD, 0, 32'd4, 0, 0, 0, 0));
        vq.push_back(mk(1, 9, 0, 24, 1, 0, 32'd0, OR_, 1, 32'd0, 1, 0, 0, 0));
        vq.push_back(mk(1, 31, 0, 27, 1, 0, 32'd0, OR_, 1, 32'd0, 1, 0, 0, 0));

        foreach (vq[i]) begin
            step(vq[i], $sformatf("vec%0d", i));
        end

        // Reset the cycle after an accepted write: it must never land in r8.
        step(mk(1, 0, 0, 8, 1, 1, 32'd3, ADD, 1, 32'd3, 0, 0, 0, 0), "r8_accept");
        reset = 1'b1;
        step(mk(1, 0, 0, 8, 1, 1, 32'd3, ADD, 0, 32'd0, 0, 0, 0, 0), "mid_reset");
        reset = 1'b0;
        step(mk(1, 8, 0, 25, 1, 0, 32'd0, OR_, 1, 32'd0, 1, 0, 0, 0), "r8_after_reset");
        step(mk(1, 1, 0, 26, 1, 0, 32'd0, OR_, 1, 32'd0, 1, 0, 0, 0), "r1_after_reset");
        step(mk(1, 0, 0, 10, 1, 1, 32'd6, ADD, 1, 32'd6, 0, 0, 0, 0), "post_reset_op");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
